peak_readout_ctrl: RTL
======================

PEAK_READOUT_CTRL -- requirements
Module: peak_readout_ctrl

Interface
REQ-001 SHALL have parameter PEAKS, default 6, number of peaks per snapshot.
REQ-002 SHALL have parameter FREQ_WIDTH, default 8, peak frequency bin width.
REQ-003 SHALL have parameter AMPL_WIDTH, default 24, peak amplitude width (≤32).
REQ-004 SHALL have parameter TIME_WIDTH, default 32, snapshot time-counter width.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port valid_in, input, 1, one-cycle pulse: peak inputs hold a complete snapshot.
REQ-008 SHALL have port counter_in, input, TIME_WIDTH, snapshot time counter.
REQ-009 SHALL have port freqs_in, input, PEAKS x FREQ_WIDTH, peak frequency bins.
REQ-010 SHALL have port amplitudes_in, input, PEAKS x AMPL_WIDTH, peak amplitudes.
REQ-011 SHALL have port chipselect, input, 1, host access qualifier.
REQ-012 SHALL have port write, input, 1, host write strobe (qualified by chipselect).
REQ-013 SHALL have port address, input, 8, host byte address.
REQ-014 SHALL have port writedata, input, 8, host write data.
REQ-015 SHALL have port readdata, output, 8, registered host read data.
REQ-016 SHALL have port snapshot_ready, output, 1, a new unread snapshot is available.

Function
REQ-017 SHALL hold two banks (front, back), each storing one full snapshot; host reads only the front bank.
REQ-018 SHALL capture all inputs into the back bank on the cycle valid_in is high.
REQ-019 SHALL use FSM states IDLE, LOCKED, LOCKED_PENDING.
REQ-020 IDLE + valid_in: capture to back, swap banks the next cycle, set snapshot_ready, increment 8-bit wrapping seq; stay IDLE.
REQ-021 Host write 0x01 to address 0xF1: IDLE -> LOCKED and snapshot_ready clears; writes of 0x01 in LOCKED or LOCKED_PENDING have no effect.
REQ-022 LOCKED + valid_in: capture to back, no swap, -> LOCKED_PENDING.
REQ-023 LOCKED_PENDING + valid_in: overwrite back bank and increment the 8-bit overrun counter, saturating at 255.
REQ-024 Host write 0x00 to 0xF1: LOCKED -> IDLE; LOCKED_PENDING -> IDLE, with swap, snapshot_ready set and seq incremented the next cycle.
REQ-025 valid_in coincident with a release write: capture first, then release; the fresh snapshot is swapped in.
REQ-026 Front-bank contents SHALL never change while in LOCKED or LOCKED_PENDING.
REQ-027 Read map, one-cycle latency (readdata valid the cycle after address):
- 0-3: counter, MSB byte first.
- 4..4+PEAKS-1: freqs[0..PEAKS-1].
- 10+4k: 0x00; 11+4k..13+4k: amplitudes[k], MSB first, for k = 0..PEAKS-1.
REQ-028 Status registers: 0xF0 = {6'b0, state!=IDLE, snapshot_ready}; 0xF1 = lock state; 0xF2 = overrun; 0xF3 = seq.
REQ-029 Fixed signature: 248-255 return 42, 53, 84, 71, 7, 25, 48, 96.
REQ-030 All other addresses SHALL read 0x00; writes to any address other than 0xF1, or with a value other than 0x00/0x01, are ignored.
REQ-031 readdata SHALL update every cycle regardless of chipselect.

Reset
REQ-032 Asserting reset SHALL immediately set: state IDLE; both banks zero; readdata 0; snapshot_ready 0; overrun 0; seq 0.
REQ-033 Reset mid-capture or while locked SHALL discard all data; no swap occurs after deassertion.

Structure
REQ-034 The shared package peak_readout_pkg SHALL hold the FSM state typedef, register addresses 0xF0-0xF3, the signature bytes, and the default widths.
REQ-035 One sub-module, peak_bank, SHALL implement a single snapshot bank (load enable, byte-address read mux) and be instantiated twice.

Verification
REQ-036 Reset, then one valid_in with counter 0x01020304, freq0 0x11, amp0 0xABCDEF -> snapshot_ready=1, seq=1; reads 0-3 = 01 02 03 04, 4 = 11, 10-13 = 00 AB CD EF.
REQ-037 Lock, then valid_in with counter 0x55 -> address 3 still reads 04 and state is LOCKED_PENDING; release -> address 3 = 55, seq=2.
REQ-038 Lock, then 300 valid_in pulses -> overrun=255; after release the front bank holds the last snapshot.
REQ-039 Release write and valid_in in the same cycle while LOCKED -> new snapshot visible after release, overrun unchanged.
REQ-040 Read 248-255 and 0x40 -> 42 53 84 71 7 25 48 96, then 0x00; write 0x07 to 0xF1 -> state unchanged.
REQ-041 Assert reset while LOCKED_PENDING -> all reads 0x00, snapshot_ready=0, state IDLE.

Source files
------------

// File: rtl/peak_readout_pkg.sv
// Shared definitions for the peak readout controller: state codes, host register
// addresses, signature bytes and default widths.
package peak_readout_pkg;

    localparam int DEF_PEAKS      = 6;
    localparam int DEF_FREQ_WIDTH = 8;
    localparam int DEF_AMPL_WIDTH = 24;
    localparam int DEF_TIME_WIDTH = 32;

    typedef logic [1:0] state_t;
    localparam state_t IDLE           = 2'd0;
    localparam state_t LOCKED         = 2'd1;
    localparam state_t LOCKED_PENDING = 2'd2;

    localparam logic [7:0] ADDR_STATUS  = 8'hF0;
    localparam logic [7:0] ADDR_LOCK    = 8'hF1;
    localparam logic [7:0] ADDR_OVERRUN = 8'hF2;
    localparam logic [7:0] ADDR_SEQ     = 8'hF3;
    localparam logic [7:0] ADDR_SIG     = 8'hF8;

    localparam logic [0:7][7:0] SIGNATURE = {8'd42, 8'd53, 8'd84, 8'd71,
                                             8'd7,  8'd25, 8'd48, 8'd96};

endpackage

// File: rtl/peak_bank.sv
// One snapshot bank: loads a full snapshot on load, and presents the byte at
// the host address combinationally.
module peak_bank
    import peak_readout_pkg::*;
#(
    parameter int PEAKS      = DEF_PEAKS,
    parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
    parameter int AMPL_WIDTH = DEF_AMPL_WIDTH,
    parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [TIME_WIDTH-1:0]         counter_in,
    input  logic [PEAKS*FREQ_WIDTH-1:0]   freqs_in,
    input  logic [PEAKS*AMPL_WIDTH-1:0]   amplitudes_in,
    input  logic [7:0]                    address,
    output logic [7:0]                    rdata
);

    logic [TIME_WIDTH-1:0]       counter_q;
    logic [PEAKS*FREQ_WIDTH-1:0] freqs_q;
    logic [PEAKS*AMPL_WIDTH-1:0] amps_q;
    logic [31:0]                 cnt32;
    logic [PEAKS-1:0][23:0]      amp24;
    int                          ai;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= '0;
            freqs_q   <= '0;
            amps_q    <= '0;
        end else if (load) begin
            counter_q <= counter_in;
            freqs_q   <= freqs_in;
            amps_q    <= amplitudes_in;
        end
    end

    assign cnt32 = 32'(counter_q);
    assign ai    = int'(address);

    // Each peak occupies a 4-byte slot starting at 10: a zero pad byte, then 3 amplitude bytes.
    always_comb begin
        rdata = 8'h00;
        for (int k = 0; k < PEAKS; k++) begin
            amp24[k] = 24'(amps_q[k*AMPL_WIDTH +: AMPL_WIDTH]);
        end
        if (ai < 4) begin
            rdata = cnt32[8*(3-ai) +: 8];
        end
        for (int k = 0; k < PEAKS; k++) begin
            if (ai == 4 + k)       rdata = 8'(freqs_q[k*FREQ_WIDTH +: FREQ_WIDTH]);
            if (ai == 11 + 4*k)    rdata = amp24[k][23:16];
            if (ai == 12 + 4*k)    rdata = amp24[k][15:8];
            if (ai == 13 + 4*k)    rdata = amp24[k][7:0];
        end
    end

endmodule

// File: rtl/peak_readout_ctrl.sv
// Double-buffered peak snapshot readout with host lock/release handshake and
// a byte-addressed register map.
module peak_readout_ctrl
    import peak_readout_pkg::*;
#(
    parameter int PEAKS      = DEF_PEAKS,
    parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
    parameter int AMPL_WIDTH = DEF_AMPL_WIDTH,
    parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [TIME_WIDTH-1:0]       counter_in,
    input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
    input  logic [PEAKS*AMPL_WIDTH-1:0] amplitudes_in,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic [7:0]                  address,
    input  logic [7:0]                  writedata,
    output logic [7:0]                  readdata,
    output logic                        snapshot_ready
);

    state_t     state, state_n;
    logic       front_sel;
    logic       swap, ovr_inc;
    logic       host_wr, lock_wr, release_wr;
    logic [7:0] overrun, seq;
    logic [7:0] rdata0, rdata1, front_rdata, rd_n;

    // front_sel names the bank the host reads; captures always go to the other one.
    peak_bank #(.PEAKS(PEAKS), .FREQ_WIDTH(FREQ_WIDTH), .AMPL_WIDTH(AMPL_WIDTH),
                .TIME_WIDTH(TIME_WIDTH)) u_bank0 (
        .clk(clk), .reset(reset), .load(valid_in && front_sel),
        .counter_in(counter_in), .freqs_in(freqs_in), .amplitudes_in(amplitudes_in),
        .address(address), .rdata(rdata0)
    );

    peak_bank #(.PEAKS(PEAKS), .FREQ_WIDTH(FREQ_WIDTH), .AMPL_WIDTH(AMPL_WIDTH),
                .TIME_WIDTH(TIME_WIDTH)) u_bank1 (
        .clk(clk), .reset(reset), .load(valid_in && !front_sel),
        .counter_in(counter_in), .freqs_in(freqs_in), .amplitudes_in(amplitudes_in),
        .address(address), .rdata(rdata1)
    );

    assign front_rdata = front_sel ? rdata1 : rdata0;
    assign host_wr     = chipselect && write && (address == ADDR_LOCK);
    assign lock_wr     = host_wr && (writedata == 8'h01);
    assign release_wr  = host_wr && (writedata == 8'h00);

    // A capture in the same cycle as a release is taken first, so it is the one swapped in.
    always_comb begin
        state_n = state;
        swap    = 1'b0;
        ovr_inc = 1'b0;
        case (state)
            IDLE: begin
                swap = valid_in;
                if (lock_wr) state_n = LOCKED;
            end
            LOCKED: begin
                if (release_wr) begin
                    state_n = IDLE;
                    swap    = valid_in;
                end else if (valid_in) begin
                    state_n = LOCKED_PENDING;
                end
            end
            LOCKED_PENDING: begin
                ovr_inc = valid_in;
                if (release_wr) begin
                    state_n = IDLE;
                    swap    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_n = 8'h00;
        if (address >= ADDR_SIG)          rd_n = SIGNATURE[address[2:0]];
        else if (address == ADDR_STATUS)  rd_n = {6'b0, state != IDLE, snapshot_ready};
        else if (address == ADDR_LOCK)    rd_n = {6'b0, state};
        else if (address == ADDR_OVERRUN) rd_n = overrun;
        else if (address == ADDR_SEQ)     rd_n = seq;
        else if (address < ADDR_STATUS)   rd_n = front_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            front_sel      <= 1'b0;
            snapshot_ready <= 1'b0;
            overrun        <= 8'h00;
            seq            <= 8'h00;
            readdata       <= 8'h00;
        end else begin
            state     <= state_n;
            front_sel <= front_sel ^ swap;
            if (lock_wr && state == IDLE) snapshot_ready <= 1'b0;
            else if (swap)                snapshot_ready <= 1'b1;
            if (swap) seq <= seq + 8'd1;
            if (ovr_inc && overrun != 8'hFF) overrun <= overrun + 8'd1;
            readdata <= rd_n;
        end
    end

endmodule
